muldiv_ctrl: RTL and testbench

Multiply/divide controller for the EXE stage: accepts MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO from EXE, owns the architectural HI/LO registers, sequences a multi-cycle multiplier and a 32-iteration radix-2 restoring divider, and drives the EXE stage `ready` term. EXE holds its instruction while `md_ready_out` is low; MEM stalls and exception flushes are handled without double-writing HI/LO.

---
 rtl/muldiv_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl.sv
// Multiply/divide controller for the EXE stage.
// Owns the architectural HI/LO registers, sequences a MUL_LAT-cycle multiply
// and a 32-iteration radix-2 restoring divide, and stalls EXE through
// md_ready_out until the result has been written.
module muldiv_ctrl #(
  parameter int MUL_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        exe_md_valid_in,
  input  logic [3:0]  exe_md_op_in,
  input  logic [31:0] exe_md_src0_in,
  input  logic [31:0] exe_md_src1_in,
  input  logic        exe_go_in,
  input  logic        flush_in,
  output logic        md_ready_out,
  output logic        md_busy_out,
  output logic [31:0] md_rdata_out,
  output logic [31:0] md_hi_out,
  output logic [31:0] md_lo_out
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  localparam logic [5:0] MUL_LAST = 6'(MUL_LAT - 1);
  localparam logic [5:0] DIV_LAST = 6'd31;

  state_t      state, state_nxt;
  logic [5:0]  cnt, cnt_nxt;
  logic [31:0] hi, lo, hi_nxt, lo_nxt;

  // Operands captured at start; later changes on the source buses are ignored.
  logic [32:0] mul_a, mul_b;
  logic [31:0] div_q;     // dividend bits shift out, quotient bits shift in
  logic [31:0] div_d;     // divisor magnitude
  logic [31:0] div_r;     // partial remainder, always < divisor
  logic        quot_neg, rem_neg;

  // Request decode; ops 9..15 match nothing and behave like op 0.
  logic op_mul, op_div, issue_ok, start_mul, start_div, mt_fire;
  logic div_signed, a_neg, b_neg;

  assign op_mul     = (exe_md_op_in == OP_MULT) || (exe_md_op_in == OP_MULTU);
  assign op_div     = (exe_md_op_in == OP_DIV)  || (exe_md_op_in == OP_DIVU);
  assign issue_ok   = (state == S_IDLE) && exe_md_valid_in && !flush_in;
  assign start_mul  = issue_ok && op_mul;
  assign start_div  = issue_ok && op_div;
  assign mt_fire    = issue_ok && exe_go_in;
  assign div_signed = (exe_md_op_in == OP_DIV);
  assign a_neg      = div_signed && exe_md_src0_in[31];
  assign b_neg      = div_signed && exe_md_src1_in[31];

  // 64-bit product of the 33-bit extended operands; the MUL cycles give the
  // multiplier array its timing slack.
  logic [63:0] mul_prod;
  assign mul_prod = {{31{mul_a[32]}}, mul_a} * {{31{mul_b[32]}}, mul_b};

  // One restoring shift-subtract step on a 33-bit shifted remainder, plus the
  // final sign fix applied when the last step completes.
  logic [32:0] div_shift;
  logic        div_ge;
  logic [31:0] div_r_nxt, div_q_nxt, div_quot, div_rem;

  assign div_shift = {div_r, div_q[31]};
  assign div_ge    = (div_shift >= {1'b0, div_d});
  assign div_r_nxt = div_ge ? (div_shift[31:0] - div_d) : div_shift[31:0];
  assign div_q_nxt = {div_q[30:0], div_ge};
  assign div_quot  = quot_neg ? -div_q_nxt : div_q_nxt;
  assign div_rem   = rem_neg  ? -div_r_nxt : div_r_nxt;

  // Next-state, counter, HI/LO write and EXE ready.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_nxt    = state;
    cnt_nxt      = '0;
    hi_nxt       = hi;
    lo_nxt       = lo;
    md_ready_out = 1'b1;
    unique case (state)
      S_IDLE: begin
        if (start_mul) begin
          state_nxt    = S_MUL;
          md_ready_out = 1'b0;
        end else if (start_div) begin
          state_nxt    = S_DIV;
          md_ready_out = 1'b0;
        end else if (mt_fire && exe_md_op_in == OP_MTHI) begin
          hi_nxt = exe_md_src0_in;
        end else if (mt_fire && exe_md_op_in == OP_MTLO) begin
          lo_nxt = exe_md_src0_in;
        end
      end
      S_MUL: begin
        md_ready_out = 1'b0;
        if (flush_in) begin
          state_nxt = S_IDLE;
        end else if (cnt == MUL_LAST) begin
          state_nxt        = S_DONE;
          {hi_nxt, lo_nxt} = mul_prod;
        end else begin
          cnt_nxt = cnt + 6'd1;
        end
      end
      S_DIV: begin
        md_ready_out = 1'b0;
        if (flush_in) begin
          state_nxt = S_IDLE;
        end else if (cnt == DIV_LAST) begin
          state_nxt = S_DONE;
          hi_nxt    = div_rem;
          lo_nxt    = div_quot;
        end else begin
          cnt_nxt = cnt + 6'd1;
        end
      end
      S_DONE: begin
        // The finished instruction is still presented; only go/flush leave.
        if (exe_go_in || flush_in) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Control state and architectural HI/LO, synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      hi    <= hi_nxt;
      lo    <= lo_nxt;
    end
  end

  // Operand capture and divide iteration.
  always_ff @(posedge clk) begin
    // NOTE: datapath registers carry no reset; they are always loaded at start
    // before being consumed, so a reset would only add fan-out.
    if (start_mul) begin
      mul_a <= (exe_md_op_in == OP_MULT) ? {exe_md_src0_in[31], exe_md_src0_in}
                                         : {1'b0, exe_md_src0_in};
      mul_b <= (exe_md_op_in == OP_MULT) ? {exe_md_src1_in[31], exe_md_src1_in}
                                         : {1'b0, exe_md_src1_in};
    end
    if (start_div) begin
      div_q    <= a_neg ? -exe_md_src0_in : exe_md_src0_in;
      div_d    <= b_neg ? -exe_md_src1_in : exe_md_src1_in;
      div_r    <= '0;
      quot_neg <= a_neg ^ b_neg;
      rem_neg  <= a_neg;
    end else if (state == S_DIV) begin
      div_q <= div_q_nxt;
      div_r <= div_r_nxt;
    end
  end

  // Status and zero-latency MF read.
  assign md_busy_out  = (state == S_MUL) || (state == S_DIV);
  assign md_hi_out    = hi;
  assign md_lo_out    = lo;
  assign md_rdata_out = (exe_md_op_in == OP_MFHI) ? hi :
                        (exe_md_op_in == OP_MFLO) ? lo : 32'd0;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed vectors with literal
// expectations plus a cycle-level arithmetic model compared every cycle.
module tb_muldiv_ctrl;

  localparam int MUL_LAT = 1;

  logic        clk;
  logic        rst_n;
  logic        valid;
  logic [3:0]  op;
  logic [31:0] src0, src1;
  logic        go, flush;
  logic        md_ready, md_busy;
  logic [31:0] md_rdata, md_hi, md_lo;

  int checks = 0;
  int errors = 0;

  muldiv_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .exe_md_valid_in (valid),
    .exe_md_op_in    (op),
    .exe_md_src0_in  (src0),
    .exe_md_src1_in  (src1),
    .exe_go_in       (go),
    .flush_in        (flush),
    .md_ready_out    (md_ready),
    .md_busy_out     (md_busy),
    .md_rdata_out    (md_rdata),
    .md_hi_out       (md_hi),
    .md_lo_out       (md_lo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_left = 0;     // cycles of busy time still to run
  bit          m_done = 0;     // result written, waiting for go/flush
  bit          m_live = 0;
  logic [31:0] m_hi, m_lo;
  logic [63:0] m_res;          // {HI, LO} the running operation will write

  function automatic logic [63:0] model_result(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      4'd1: begin p = 64'(sa * sb); return p; end
      4'd2: begin p = {32'd0, a} * {32'd0, b}; return p; end
      4'd3: begin
        if (b == 32'd0) return {a, (sa < 0) ? 32'd1 : 32'hFFFFFFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_left = 0; m_done = 0; m_hi = '0; m_lo = '0; m_live = 1;
    end else if (m_left > 0) begin
      if (flush) m_left = 0;
      else begin
        m_left--;
        if (m_left == 0) begin {m_hi, m_lo} = m_res; m_done = 1; end
      end
    end else if (m_done) begin
      if (go || flush) m_done = 0;
    end else if (valid && !flush) begin
      if (op == 4'd1 || op == 4'd2) begin
        m_left = MUL_LAT; m_res = model_result(op, src0, src1);
      end else if (op == 4'd3 || op == 4'd4) begin
        m_left = 32; m_res = model_result(op, src0, src1);
      end else if (go && op == 4'd7) m_hi = src0;
      else if (go && op == 4'd8) m_lo = src0;
    end
  end

  // Compare process: outputs against the model, 1 time unit after each edge.
  always @(posedge clk) begin
    logic exp_start, exp_ready;
    logic [31:0] exp_rdata;
    #1;
    if (m_live) begin
      exp_start = (m_left == 0) && !m_done && valid && !flush && (op >= 4'd1 && op <= 4'd4);
      exp_ready = (m_left == 0) && !exp_start;
      exp_rdata = (op == 4'd5) ? m_hi : (op == 4'd6) ? m_lo : 32'd0;
      check("model ready", {31'd0, md_ready}, {31'd0, exp_ready});
      check("model busy",  {31'd0, md_busy},  {31'd0, m_left > 0});
      check("model rdata", md_rdata, exp_rdata);
      check("model hi",    md_hi, m_hi);
      check("model lo",    md_lo, m_lo);
    end
  end

  // ---------------- directed stimulus ----------------
  // Presents a mul/div, measures ready-low cycles, checks the result, holds
  // DONE for 'hold' cycles, then leaves by go or flush.
  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       input int lat, input logic [31:0] eh, input logic [31:0] el,
                       input int hold, input bit by_flush, input string nm);
    int low;
    low = 0;
    valid = 1'b1; op = o; src0 = a; src1 = b; go = 1'b0; flush = 1'b0;
    #1;
    while (!md_ready && low < 100) begin
      low++;
      @(negedge clk); #1;
      if (low == 1) begin src0 = ~a; src1 = b ^ 32'h5A5A5A5A; end
    end
    check({nm, " ready-low cycles"}, 32'(low), 32'(lat));
    check({nm, " hi"}, md_hi, eh);
    check({nm, " lo"}, md_lo, el);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk); #1;
      check({nm, " hold ready"}, {31'd0, md_ready}, 32'd1);
      check({nm, " hold busy"},  {31'd0, md_busy},  32'd0);
      check({nm, " hold hi"}, md_hi, eh);
    end
    if (by_flush) flush = 1'b1; else go = 1'b1;
    @(negedge clk);
    valid = 1'b0; op = 4'd0; go = 1'b0; flush = 1'b0;
  endtask

  task automatic mt(input logic [3:0] o, input logic [31:0] d, input bit fl);
    valid = 1'b1; op = o; src0 = d; go = 1'b1; flush = fl;
    @(negedge clk);
    valid = 1'b0; op = 4'd0; go = 1'b0; flush = 1'b0;
  endtask

  task automatic mf(input logic [3:0] o, input logic [31:0] exp, input string nm);
    valid = 1'b1; op = o; go = 1'b1;
    #1;
    check({nm, " rdata"}, md_rdata, exp);
    check({nm, " ready"}, {31'd0, md_ready}, 32'd1);
    @(negedge clk);
    valid = 1'b0; op = 4'd0; go = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "bench timeout");
  end

  initial begin
    rst_n = 1'b0; valid = 1'b0; op = 4'd0; src0 = '0; src1 = '0; go = 1'b0; flush = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset ready", {31'd0, md_ready}, 32'd1);
    check("reset busy",  {31'd0, md_busy},  32'd0);
    check("reset rdata", md_rdata, 32'd0);
    check("reset hi", md_hi, 32'd0);
    check("reset lo", md_lo, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(4'd1, 32'hFFFFFFFD, 32'd5, 2, 32'hFFFFFFFF, 32'hFFFFFFF1, 0, 0, "mult");
    issue(4'd2, 32'hFFFFFFFD, 32'd5, 2, 32'h00000004, 32'hFFFFFFF1, 0, 0, "multu");
    issue(4'd3, 32'hFFFFFFF9, 32'd2, 33, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, 0, "div -7/2");
    issue(4'd4, 32'd100, 32'd7, 33, 32'd2, 32'd14, 0, 0, "divu 100/7");
    issue(4'd4, 32'h80000000, 32'd0, 33, 32'h80000000, 32'hFFFFFFFF, 0, 0, "divu by zero");
    issue(4'd3, 32'd7, 32'hFFFFFFFE, 33, 32'd1, 32'hFFFFFFFD, 0, 0, "div 7/-2");
    issue(4'd3, 32'h80000000, 32'hFFFFFFFF, 33, 32'd0, 32'h80000000, 0, 0, "div min/-1");
    issue(4'd3, 32'hFFFFFFF9, 32'd0, 33, 32'hFFFFFFF9, 32'd1, 0, 0, "div -7/0");

    // DONE held with go low, then back-to-back multiplies and a flush exit.
    issue(4'd1, 32'd6, 32'd7, 2, 32'd0, 32'd42, 3, 0, "mult hold");
    issue(4'd1, 32'hFFFFFFFF, 32'h80000000, 2, 32'd0, 32'h80000000, 0, 0, "mult b2b");
    issue(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 2, 32'hFFFFFFFE, 32'h00000001, 0, 1, "multu flush exit");

    // MT/MF traffic.
    mt(4'd7, 32'hDEADBEEF, 0);
    check("mthi visible", md_hi, 32'hDEADBEEF);
    mf(4'd5, 32'hDEADBEEF, "mfhi");
    mf(4'd6, 32'h00000001, "mflo");
    mt(4'd8, 32'hCAFEF00D, 1);
    check("mtlo flushed", md_lo, 32'h00000001);

    // Unused op code with valid set: no stall, no state change.
    valid = 1'b1; op = 4'd9; src0 = 32'h12345678; go = 1'b1;
    #1;
    check("op9 ready", {31'd0, md_ready}, 32'd1);
    @(negedge clk);
    valid = 1'b0; op = 4'd0; go = 1'b0;
    #1;
    check("op9 busy", {31'd0, md_busy}, 32'd0);

    // DIV flushed at iteration 10 leaves HI/LO untouched.
    mt(4'd7, 32'h11111111, 0);
    mt(4'd8, 32'h11111111, 0);
    valid = 1'b1; op = 4'd3; src0 = 32'd1000; src1 = 32'd3;
    repeat (11) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; valid = 1'b0; op = 4'd0;
    #1;
    check("flush ready", {31'd0, md_ready}, 32'd1);
    check("flush busy",  {31'd0, md_busy},  32'd0);
    check("flush hi", md_hi, 32'h11111111);
    check("flush lo", md_lo, 32'h11111111);

    // Reset in the middle of a divide.
    @(negedge clk);
    valid = 1'b1; op = 4'd4; src0 = 32'd500; src1 = 32'd9;
    repeat (6) @(negedge clk);
    rst_n = 1'b0; valid = 1'b0; op = 4'd0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mid-div reset ready", {31'd0, md_ready}, 32'd1);
    check("mid-div reset busy",  {31'd0, md_busy},  32'd0);
    check("mid-div reset hi", md_hi, 32'd0);
    check("mid-div reset lo", md_lo, 32'd0);

    @(negedge clk);
    issue(4'd4, 32'd500, 32'd9, 33, 32'd5, 32'd55, 0, 0, "divu after reset");
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
